// File: rtl/pmod_bus_master_pkg.sv
// Shared types and helpers for the PMOD memory-bus master: FSM encoding,
// bus geometry and the byte-strobe / legality calculation.
package pmod_pkg;

   localparam int BUS_BYTES = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CHECK = 2'd1,
      REQ   = 2'd2,
      DONE  = 2'd3
   } bus_state_t;

   typedef struct packed {
      logic [BUS_BYTES-1:0] strb;
      logic                 legal;
   } strb_res_t;

   // Single-beat access: power-of-two size that stays inside one 8-byte word.
   function automatic strb_res_t calc_strb(input logic [3:0] len, input logic [2:0] addr_lo);
      strb_res_t r;
      // 8-bit arithmetic on purpose: len=8 wraps 1<<8 to 0, and 0-1 gives 8'hFF.
      r.strb  = ((8'd1 << len) - 8'd1) << addr_lo;
      r.legal = ((len == 4'd1) || (len == 4'd2) || (len == 4'd4) || (len == 4'd8)) &&
                (({2'b00, addr_lo} + {1'b0, len}) <= 5'd8);
      return r;
   endfunction

endpackage

// File: rtl/pmod_bus_master_if.sv
// Command-side and memory-side signals of the PMOD bus master, bundled so the
// master and its environment connect through one port.
interface pmod_bus_master_if #(
   parameter int AW = 32
);
   logic          write_req;
   logic          read_req;
   logic [9:0]    len;
   logic [AW-1:0] address;
   logic [63:0]   wdata;
   logic          busy;
   logic          done;
   logic          err;
   logic [63:0]   rdata;

   logic          mem_valid;
   logic          mem_write;
   logic [AW-1:0] mem_addr;
   logic [63:0]   mem_wdata;
   logic [7:0]    mem_wstrb;
   logic          mem_ready;
   logic [63:0]   mem_rdata;
   logic          mem_err;

   modport master (
      input  write_req, read_req, len, address, wdata, mem_ready, mem_rdata, mem_err,
      output busy, done, err, rdata, mem_valid, mem_write, mem_addr, mem_wdata, mem_wstrb
   );

   modport slave (
      output write_req, read_req, len, address, wdata, mem_ready, mem_rdata, mem_err,
      input  busy, done, err, rdata, mem_valid, mem_write, mem_addr, mem_wdata, mem_wstrb
   );
endinterface

// File: rtl/pmod_bus_master_strb_gen.sv
// Combinational byte-strobe and size/alignment check for one bus word.
module pmod_strb_gen
   import pmod_pkg::*;
(
   input  logic [3:0]           len,
   input  logic [2:0]           addr_lo,
   output logic [BUS_BYTES-1:0] wstrb,
   output logic                 legal
);
   strb_res_t res;

   assign res   = calc_strb(len, addr_lo);
   assign wstrb = res.strb;
   assign legal = res.legal;
endmodule

// File: rtl/pmod_bus_master.sv
// Single-beat memory-bus master: latches a command, checks it, runs one
// valid/ready transfer with timeout and reports done/err/rdata.
module pmod_bus_master
   import pmod_pkg::*;
#(
   parameter int TIMEOUT = 256,
   parameter int AW      = 32
) (
   input logic               clk,
   input logic               reset,
   pmod_bus_master_if.master bus
);
   localparam logic [1:0] S_IDLE  = IDLE;
   localparam logic [1:0] S_CHECK = CHECK;
   localparam logic [1:0] S_REQ   = REQ;
   localparam logic [1:0] S_DONE  = DONE;
   localparam int              CW       = $clog2(TIMEOUT);
   localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT - 1);

   logic [1:0]    state_q, state_d;
   logic          dir_q, dir_d;
   logic [9:0]    len_q, len_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [63:0]   wdata_q, wdata_d;
   logic [63:0]   rdata_q, rdata_d;
   logic          err_q, err_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic [7:0]    strb;
   logic          strb_legal;
   logic          legal;

   pmod_strb_gen u_strb_gen (
      .len     (len_q[3:0]),
      .addr_lo (addr_q[2:0]),
      .wstrb   (strb),
      .legal   (strb_legal)
   );

   // Only the low nibble reaches the strobe helper; any upper bit is a burst.
   assign legal = strb_legal && (len_q[9:4] == 6'd0);

   always_comb begin
      // NOTE: every _d takes its _q value first so no path through the case leaves it unassigned (no latch).
      state_d = state_q;
      dir_d   = dir_q;
      len_d   = len_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (bus.write_req || bus.read_req) begin
               state_d = S_CHECK;
               dir_d   = bus.write_req;
               len_d   = bus.len;
               addr_d  = bus.address;
               wdata_d = bus.wdata;
            end
         end
         S_CHECK: begin
            if (legal) begin
               state_d = S_REQ;
            end else begin
               state_d = S_DONE;
               err_d   = 1'b1;
            end
         end
         S_REQ: begin
            // mem_ready beats the timeout terminal count when both land together.
            if (bus.mem_ready) begin
               state_d = S_DONE;
               err_d   = bus.mem_err;
               cnt_d   = '0;
               if (!dir_q) rdata_d = bus.mem_rdata;
            end else if (cnt_q == CNT_LAST) begin
               state_d = S_DONE;
               err_d   = 1'b1;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
            err_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
      if (reset) begin
         state_q <= S_IDLE;
         dir_q   <= 1'b0;
         len_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         dir_q   <= dir_d;
         len_q   <= len_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.busy      = (state_q != S_IDLE);
   assign bus.done      = (state_q == S_DONE);
   assign bus.err       = err_q;
   assign bus.rdata     = rdata_q;
   assign bus.mem_valid = (state_q == S_REQ);
   assign bus.mem_write = (state_q == S_REQ) && dir_q;
   assign bus.mem_addr  = (state_q == S_REQ) ? {addr_q[AW-1:3], 3'b000} : '0;
   assign bus.mem_wdata = wdata_q;
   assign bus.mem_wstrb = (state_q == S_REQ) ? strb : 8'h00;
endmodule

// File: tb/tb_pmod_bus_master.sv
// Directed bench for pmod_bus_master: table of single transactions plus
// hand-written collision and mid-transfer reset sequences (TIMEOUT=16).
module tb_pmod_bus_master;
   localparam int AW = 32;

   typedef struct {
      logic        wr;
      logic [9:0]  len;
      logic [31:0] addr;
      logic [63:0] wdata;
      int          waits;
      logic [63:0] rsp;
      logic        rsp_err;
      logic [7:0]  e_strb;
      int          e_nvalid;
      int          e_lat;
      logic        e_err;
      logic [63:0] e_rdata;
   } vec_t;

   logic clk = 1'b0;
   logic reset;
   int   tests = 0;
   int   fails = 0;
   vec_t vecs[12];

   pmod_bus_master_if #(.AW(AW)) bus ();

   pmod_bus_master #(.TIMEOUT(16), .AW(AW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.master)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      int   nvalid = 0;
      int   lat = 0;
      logic got_err = 1'b0;
      bit   seen = 1'b0;
      string tag = $sformatf("v%0d", idx);
      @(negedge clk);
      check({tag, " busy_before"}, bus.busy, 0);
      bus.write_req = v.wr;
      bus.read_req  = !v.wr;
      bus.len       = v.len;
      bus.address   = v.addr;
      bus.wdata     = v.wdata;
      bus.mem_rdata = v.rsp;
      bus.mem_err   = v.rsp_err;
      for (int t = 1; t <= 60 && !seen; t++) begin
         @(negedge clk);
         bus.write_req = 1'b0;
         bus.read_req  = 1'b0;
         bus.mem_ready = 1'b0;
         if (bus.mem_valid) begin
            nvalid++;
            check({tag, " mem_addr"}, bus.mem_addr, {v.addr[31:3], 3'b000});
            check({tag, " mem_wstrb"}, bus.mem_wstrb, v.e_strb);
            check({tag, " mem_write"}, bus.mem_write, v.wr);
            if (v.wr) check({tag, " mem_wdata"}, bus.mem_wdata, v.wdata);
            bus.mem_ready = (nvalid == v.waits + 1);
         end
         if (bus.done) begin
            seen    = 1'b1;
            lat     = t;
            got_err = bus.err;
            check({tag, " rdata"}, bus.rdata, v.e_rdata);
         end
      end
      check({tag, " done_seen"}, seen, 1);
      check({tag, " latency"}, lat, v.e_lat);
      check({tag, " valid_cycles"}, nvalid, v.e_nvalid);
      check({tag, " err"}, got_err, v.e_err);
   endtask

   initial begin
      int nvalid;
      int ndone;
      bit seen;

      //               wr    len    addr          wdata                  waits rsp                    rerr strb   nv lat err rdata
      vecs[0]  = '{1'b1, 10'd4,  32'h1000_0004, 64'hDEADBEEF_00000000, 0,   64'h0,                 1'b0, 8'hF0, 1,  3, 1'b0, 64'h0};
      vecs[1]  = '{1'b0, 10'd2,  32'h0000_0012, 64'h0,                 3,   64'h0000_0000_1234_0000, 1'b0, 8'h0C, 4,  6, 1'b0, 64'h1234_0000};
      vecs[2]  = '{1'b1, 10'd4,  32'h0000_0006, 64'h0,                 0,   64'h0,                 1'b0, 8'h00, 0,  2, 1'b1, 64'h1234_0000};
      vecs[3]  = '{1'b0, 10'd3,  32'h0000_0000, 64'h0,                 0,   64'hFFFF,              1'b0, 8'h00, 0,  2, 1'b1, 64'h1234_0000};
      vecs[4]  = '{1'b1, 10'd8,  32'h0000_0100, 64'h0123_4567_89AB_CDEF, 1, 64'h0,                 1'b0, 8'hFF, 2,  4, 1'b0, 64'h1234_0000};
      vecs[5]  = '{1'b0, 10'd1,  32'h0000_0207, 64'h0,                 0,   64'hAB00_0000_0000_0000, 1'b0, 8'h80, 1,  3, 1'b0, 64'hAB00_0000_0000_0000};
      vecs[6]  = '{1'b1, 10'd2,  32'h0000_0306, 64'h1122_0000_0000_0000, 2, 64'h0,                 1'b1, 8'hC0, 3,  5, 1'b1, 64'hAB00_0000_0000_0000};
      vecs[7]  = '{1'b1, 10'd0,  32'h0000_0000, 64'h0,                 0,   64'h0,                 1'b0, 8'h00, 0,  2, 1'b1, 64'hAB00_0000_0000_0000};
      vecs[8]  = '{1'b0, 10'd17, 32'h0000_0000, 64'h0,                 0,   64'h77,                1'b0, 8'h00, 0,  2, 1'b1, 64'hAB00_0000_0000_0000};
      vecs[9]  = '{1'b1, 10'd8,  32'h0000_0001, 64'h0,                 0,   64'h0,                 1'b0, 8'h00, 0,  2, 1'b1, 64'hAB00_0000_0000_0000};
      vecs[10] = '{1'b0, 10'd4,  32'h0000_0400, 64'h0,                 255, 64'hDEAD,              1'b0, 8'h0F, 16, 18, 1'b1, 64'hAB00_0000_0000_0000};
      vecs[11] = '{1'b0, 10'd4,  32'h0000_0404, 64'h0,                 15,  64'h5555_0000_0000,    1'b0, 8'hF0, 16, 18, 1'b0, 64'h5555_0000_0000};

      reset         = 1'b1;
      bus.write_req = 1'b0;
      bus.read_req  = 1'b0;
      bus.len       = '0;
      bus.address   = '0;
      bus.wdata     = '0;
      bus.mem_ready = 1'b0;
      bus.mem_rdata = '0;
      bus.mem_err   = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("rst busy", bus.busy, 0);
      check("rst done", bus.done, 0);
      check("rst err", bus.err, 0);
      check("rst mem_valid", bus.mem_valid, 0);
      check("rst mem_write", bus.mem_write, 0);
      check("rst mem_wstrb", bus.mem_wstrb, 0);
      check("rst mem_addr", bus.mem_addr, 0);
      check("rst rdata", bus.rdata, 0);

      for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

      // Collision: simultaneous write+read in IDLE, then more requests while busy.
      @(negedge clk);
      bus.write_req = 1'b1;
      bus.read_req  = 1'b1;
      bus.len       = 10'd4;
      bus.address   = 32'h0000_0020;
      bus.wdata     = 64'h0000_0000_CAFE_F00D;
      bus.mem_ready = 1'b1;
      @(negedge clk);
      check("col busy", bus.busy, 1);
      bus.read_req = 1'b0;
      bus.address  = 32'h0000_0080;
      nvalid = 0;
      ndone  = 0;
      for (int t = 0; t < 20; t++) begin
         @(negedge clk);
         bus.write_req = (t < 2);
         bus.read_req  = (t == 1);
         if (bus.mem_valid) begin
            nvalid++;
            check("col mem_write", bus.mem_write, 1);
            check("col mem_addr", bus.mem_addr, 32'h0000_0020);
            check("col mem_wstrb", bus.mem_wstrb, 8'h0F);
         end
         if (bus.done) ndone++;
      end
      check("col valid_cycles", nvalid, 1);
      check("col done_pulses", ndone, 1);
      bus.write_req = 1'b0;
      bus.read_req  = 1'b0;
      bus.mem_ready = 1'b0;

      // Reset while a read is stalled in REQ.
      @(negedge clk);
      bus.read_req = 1'b1;
      bus.len      = 10'd4;
      bus.address  = 32'h0000_0040;
      seen = 1'b0;
      for (int t = 0; t < 6 && !seen; t++) begin
         @(negedge clk);
         bus.read_req = 1'b0;
         seen = bus.mem_valid;
      end
      check("rstreq mem_valid_seen", seen, 1);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("rstreq mem_valid", bus.mem_valid, 0);
      check("rstreq busy", bus.busy, 0);
      check("rstreq done", bus.done, 0);
      ndone = 0;
      for (int t = 0; t < 20; t++) begin
         @(negedge clk);
         if (bus.done || bus.mem_valid) ndone++;
      end
      check("rstreq no_activity", ndone, 0);
      run_vec(100, vecs[0]);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
